// File: rtl/nfu_3.sv
// -----------------------------------------------------------------------------
// nfu_3 : NFU-3 activation stage.
//   Takes G signed partial sums from NFU-2 and applies a per-lane activation:
//   a piecewise-linear table (PWL), ReLU, or identity. Two register stages with
//   valid/ready on both sides; the coefficient table can be rewritten while
//   vectors stream. Lanes clamped in PWL mode are counted in a sticky counter.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   i_valid/o_ready       upstream handshake, i_partial_sum + i_func
//   i_partial_sum         G lanes, lane k at [k*BIT_WIDTH +: BIT_WIDTH], signed
//   i_func                0=PWL 1=ReLU 2/3=identity
//   o_valid/i_ready       downstream handshake for o_act
//   o_act                 G activations, same lane layout, signed
//   i_coef_we/addr/a/b    coefficient table write port (slope a, intercept b)
//   o_sat_cnt             saturated-lane event count, sticks at 16'hFFFF
// -----------------------------------------------------------------------------

// Per-lane datapath: s1 holds x and the looked-up coefficients, s2 holds the
// activation and whether it was clamped.
module nfu_3_lane #(
  parameter int BIT_WIDTH = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_s1,
  input  logic                 ld_s2,
  input  logic [1:0]           func_s1,
  input  logic [BIT_WIDTH-1:0] x_in,
  input  logic [BIT_WIDTH-1:0] a_in,
  input  logic [BIT_WIDTH-1:0] b_in,
  output logic [BIT_WIDTH-1:0] act,
  output logic                 sat
);
  localparam int TW = BIT_WIDTH + 2;
  localparam int PW = 2 * BIT_WIDTH;
  localparam logic signed [TW-1:0] T_MAX = {3'b000, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [TW-1:0] T_MIN = {3'b111, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [BIT_WIDTH-1:0] OUT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] OUT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  logic signed [BIT_WIDTH-1:0] x_q, x_d, a_q, a_d, b_q, b_d;
  logic [BIT_WIDTH-1:0] act_q, act_d;
  logic sat_q, sat_d;
  logic signed [PW-1:0] prod;
  logic signed [TW-1:0] t;

  always_comb begin
    x_d = x_q;
    a_d = a_q;
    b_d = b_q;
    if (ld_s1) begin
      x_d = x_in;
      a_d = a_in;
      b_d = b_in;
    end

    prod = PW'(a_q) * PW'(x_q);
    // Shifted product is kept in BIT_WIDTH+2 bits before adding the intercept;
    // the arithmetic shift floors toward -inf.
    t = TW'(prod >>> FRAC_BITS) + TW'(b_q);

    act_d = act_q;
    sat_d = sat_q;
    if (ld_s2) begin
      sat_d = 1'b0;
      unique case (func_s1)
        2'd0: begin
          if (t > T_MAX) begin
            act_d = OUT_MAX;
            sat_d = 1'b1;
          end else if (t < T_MIN) begin
            act_d = OUT_MIN;
            sat_d = 1'b1;
          end else begin
            act_d = t[BIT_WIDTH-1:0];
          end
        end
        2'd1:    act_d = x_q[BIT_WIDTH-1] ? '0 : x_q;
        default: act_d = x_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      act_q <= '0;
      sat_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      a_q   <= a_d;
      b_q   <= b_d;
      act_q <= act_d;
      sat_q <= sat_d;
    end
  end

  assign act = act_q;
  assign sat = sat_q;
endmodule

module nfu_3 #(
  parameter int BIT_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int G         = 4,
  parameter int SEG_BITS  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [G*BIT_WIDTH-1:0] i_partial_sum,
  input  logic [1:0]             i_func,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [G*BIT_WIDTH-1:0] o_act,
  input  logic                   i_coef_we,
  input  logic [SEG_BITS-1:0]    i_coef_addr,
  input  logic [BIT_WIDTH-1:0]   i_coef_a,
  input  logic [BIT_WIDTH-1:0]   i_coef_b,
  output logic [15:0]            o_sat_cnt
);
  localparam int NSEG = 1 << SEG_BITS;
  localparam logic [BIT_WIDTH-1:0] A_ONE = BIT_WIDTH'(1) << FRAC_BITS;

  logic [NSEG-1:0][BIT_WIDTH-1:0] coef_a_q, coef_a_d, coef_b_q, coef_b_d;
  logic [2:1]  vld_pipe_q, vld_pipe_d;
  logic [1:0]  func_s1_q, func_s1_d;
  logic [15:0] sat_cnt_q, sat_cnt_d;
  logic [16:0] sat_sum;
  logic        s1_adv, s2_adv, ld_s1, ld_s2;

  logic [G-1:0][BIT_WIDTH-1:0] x_in, act;
  logic [G-1:0]                sat;

  assign x_in  = i_partial_sum;
  assign o_act = act;

  // s2 frees when empty or draining; s1 frees when empty or moving into s2.
  assign s2_adv  = !vld_pipe_q[2] || i_ready;
  assign s1_adv  = !vld_pipe_q[1] || s2_adv;
  assign o_ready = s1_adv;
  assign ld_s1   = s1_adv && i_valid;
  assign ld_s2   = s2_adv && vld_pipe_q[1];
  assign o_valid = vld_pipe_q[2];

  always_comb begin
    vld_pipe_d[1] = s1_adv ? i_valid : vld_pipe_q[1];
    vld_pipe_d[2] = s2_adv ? vld_pipe_q[1] : vld_pipe_q[2];
    func_s1_d     = ld_s1 ? i_func : func_s1_q;

    // Lookups read coef_*_q, so a write on the same edge is seen only by
    // vectors entering s1 afterwards.
    coef_a_d = coef_a_q;
    coef_b_d = coef_b_q;
    if (i_coef_we) begin
      coef_a_d[i_coef_addr] = i_coef_a;
      coef_b_d[i_coef_addr] = i_coef_b;
    end

    // Clamp flags are counted as the vector leaves s2; sticky at all-ones.
    sat_sum = {1'b0, sat_cnt_q};
    if (o_valid && i_ready) begin
      for (int k = 0; k < G; k++) sat_sum = sat_sum + 17'(sat[k]);
    end
    sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      func_s1_q  <= '0;
      coef_a_q   <= {NSEG{A_ONE}};
      coef_b_q   <= '0;
      sat_cnt_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      func_s1_q  <= func_s1_d;
      coef_a_q   <= coef_a_d;
      coef_b_q   <= coef_b_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign o_sat_cnt = sat_cnt_q;

  for (genvar k = 0; k < G; k++) begin : g_lane
    // Segment is the top SEG_BITS of x as unsigned: negatives land high.
    logic [SEG_BITS-1:0] seg;
    assign seg = x_in[k][BIT_WIDTH-1 -: SEG_BITS];

    nfu_3_lane #(
      .BIT_WIDTH (BIT_WIDTH),
      .FRAC_BITS (FRAC_BITS)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld_s1   (ld_s1),
      .ld_s2   (ld_s2),
      .func_s1 (func_s1_q),
      .x_in    (x_in[k]),
      .a_in    (coef_a_q[seg]),
      .b_in    (coef_b_q[seg]),
      .act     (act[k]),
      .sat     (sat[k])
    );
  end
endmodule

// File: tb/tb_nfu_3.sv
// Bench for nfu_3: directed cases with literal expectations plus a random
// stream checked every cycle against a transaction-level model (queue of
// expected vectors, coefficient array, saturation count).
module tb_nfu_3;
  localparam int BW   = 16;
  localparam int G    = 4;
  localparam int SB   = 4;
  localparam int NSEG = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_valid = 1'b0, i_ready = 1'b0, i_coef_we = 1'b0;
  logic o_ready, o_valid;
  logic [G*BW-1:0] i_partial_sum = '0, o_act;
  logic [1:0]      i_func = '0;
  logic [SB-1:0]   i_coef_addr = '0;
  logic [BW-1:0]   i_coef_a = '0, i_coef_b = '0;
  logic [15:0]     o_sat_cnt;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  nfu_3 dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_partial_sum(i_partial_sum), .i_func(i_func), .o_valid(o_valid),
    .i_ready(i_ready), .o_act(o_act), .i_coef_we(i_coef_we),
    .i_coef_addr(i_coef_addr), .i_coef_a(i_coef_a), .i_coef_b(i_coef_b),
    .o_sat_cnt(o_sat_cnt)
  );

  typedef struct {
    logic [G*BW-1:0] act;
    int              nsat;
    longint          acc_at;
  } exp_t;

  exp_t        q[$];
  logic [BW-1:0] tbl_a [NSEG];
  logic [BW-1:0] tbl_b [NSEG];
  int          sat_m = 0;
  longint      edges = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Activation from the rules: exact product, floor shift, 18-bit sum, clamp.
  function automatic void lane_model(input logic [BW-1:0] x, input logic [BW-1:0] a,
                                     input logic [BW-1:0] b, input logic [1:0] f,
                                     output logic [BW-1:0] y, output int s);
    longint xs, av, bv, t;
    xs = longint'($signed(x));
    av = longint'($signed(a));
    bv = longint'($signed(b));
    s  = 0;
    if (f == 2'd1) y = (xs < 0) ? '0 : x;
    else if (f != 2'd0) y = x;
    else begin
      t = ((xs * av) >>> 8) + bv;
      t = t & 262143;
      if (t >= 131072) t = t - 262144;
      if (t > 32767) begin y = 16'h7FFF; s = 1; end
      else if (t < -32768) begin y = 16'h8000; s = 1; end
      else y = t[15:0];
    end
  endfunction

  function automatic void vec_model(input logic [G*BW-1:0] v, input logic [1:0] f,
                                    output logic [G*BW-1:0] y, output int ns);
    logic [BW-1:0] x, yl;
    logic [SB-1:0] seg;
    int s;
    ns = 0;
    y  = '0;
    for (int k = 0; k < G; k++) begin
      x   = v[k*BW +: BW];
      seg = x[BW-1 -: SB];
      lane_model(x, tbl_a[seg], tbl_b[seg], f, yl, s);
      y[k*BW +: BW] = yl;
      ns += s;
    end
  endfunction

  // Compare process: checks outputs each cycle, then advances the model
  // through the coming rising edge.
  logic m_ev, m_er, m_acc, m_pop;
  exp_t m_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      for (int s = 0; s < NSEG; s++) begin
        tbl_a[s] = 16'h0100;
        tbl_b[s] = 16'h0000;
      end
      sat_m = 0;
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_act", o_act, 0);
      chk("rst_o_sat_cnt", o_sat_cnt, 0);
    end else begin
      m_ev = (q.size() > 0) && (q[0].acc_at + 2 <= edges);
      m_er = (q.size() < 2) || i_ready;
      chk("o_valid", o_valid, m_ev);
      chk("o_ready", o_ready, m_er);
      if (m_ev) chk("o_act", o_act, q[0].act);
      chk("o_sat_cnt", o_sat_cnt, 64'(sat_m));
      m_acc = i_valid && m_er;
      m_pop = m_ev && i_ready;
      if (m_pop) begin
        sat_m = sat_m + q[0].nsat;
        if (sat_m > 65535) sat_m = 65535;
        void'(q.pop_front());
      end
      if (m_acc) begin
        vec_model(i_partial_sum, i_func, m_e.act, m_e.nsat);
        m_e.acc_at = edges;
        q.push_back(m_e);
      end
      if (i_coef_we) begin
        tbl_a[i_coef_addr] = i_coef_a;
        tbl_b[i_coef_addr] = i_coef_b;
      end
      edges++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [G*BW-1:0] sent [8];
  logic [G*BW-1:0] gotv [8];
  int idx, got, cyc_n;
  bit saw_drop, acc;

  initial begin
    repeat (2) cyc();
    rst_n   = 1'b1;
    i_ready = 1'b1;

    // 1: identity table after reset, latency 2
    i_func        = 2'd0;
    i_partial_sum = {16'h8000, 16'h7FFF, 16'hFF00, 16'h0100};
    i_valid       = 1'b1;
    cyc();
    i_valid = 1'b0;
    chk("t1_not_yet_valid", o_valid, 0);
    cyc();
    chk("t1_valid", o_valid, 1);
    chk("t1_act", o_act, 64'h8000_7FFF_FF00_0100);
    chk("t1_sat", o_sat_cnt, 0);
    cyc();

    // 2: seg0 = 0.5x + 0.25
    i_coef_we = 1'b1; i_coef_addr = 4'd0; i_coef_a = 16'h0080; i_coef_b = 16'h0040;
    cyc();
    i_coef_we     = 1'b0;
    i_partial_sum = {4{16'h0280}};
    i_valid       = 1'b1;
    cyc();
    i_valid = 1'b0;
    cyc();
    chk("t2_act", o_act, {4{16'h0180}});

    // 3: saturation and sticky counter
    i_coef_we = 1'b1; i_coef_addr = 4'd7; i_coef_a = 16'h0400; i_coef_b = 16'h0000;
    cyc();
    i_coef_we     = 1'b0;
    i_partial_sum = {4{16'h7000}};
    i_valid       = 1'b1;
    cyc();
    i_valid = 1'b0;
    cyc();
    chk("t3_act", o_act, {4{16'h7FFF}});
    cyc();
    chk("t3_sat4", o_sat_cnt, 4);
    i_valid = 1'b1;
    repeat (16400) cyc();
    i_valid = 1'b0;
    repeat (3) cyc();
    chk("t3_sat_stuck", o_sat_cnt, 16'hFFFF);

    // 4: ReLU
    i_func        = 2'd1;
    i_partial_sum = {16'h8000, 16'h0042, 16'h0000, 16'hFF80};
    i_valid       = 1'b1;
    cyc();
    i_valid = 1'b0;
    cyc();
    chk("t4_act", o_act, {16'h0000, 16'h0042, 16'h0000, 16'h0000});
    cyc();

    // 5: backpressure, 3-cycle stall mid-stream
    i_func = 2'd2;
    for (int k = 0; k < 8; k++) sent[k] = {4{16'(k * 16'h0111 + 1)}};
    idx = 0; got = 0; cyc_n = 0; saw_drop = 0;
    while (got < 8 && cyc_n < 60) begin
      i_ready = !(cyc_n >= 4 && cyc_n < 7);
      i_valid = (idx < 8);
      if (idx < 8) i_partial_sum = sent[idx];
      #1;
      if (i_valid && !o_ready) saw_drop = 1;
      if (o_valid && i_ready) begin
        if (got < 8) gotv[got] = o_act;
        got++;
      end
      acc = i_valid && o_ready;
      cyc();
      if (acc) idx++;
      cyc_n++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("t5_count", got, 8);
    chk("t5_oready_drop", saw_drop, 1);
    for (int k = 0; k < 8; k++) chk("t5_order", gotv[k], sent[k]);

    // 6: same-edge write/lookup on seg0, then reset mid-stream
    i_func        = 2'd0;
    i_partial_sum = {4{16'h0280}};
    i_valid       = 1'b1;
    i_coef_we = 1'b1; i_coef_addr = 4'd0; i_coef_a = 16'h0200; i_coef_b = 16'h0000;
    cyc();
    i_coef_we = 1'b0;
    cyc();
    i_valid = 1'b0;
    chk("t6_old_coef", o_act, {4{16'h0180}});
    cyc();
    chk("t6_new_coef", o_act, {4{16'h0500}});
    i_func        = 2'd2;
    i_partial_sum = 64'h1234_5678_9ABC_DEF0;
    i_valid       = 1'b1;
    repeat (2) cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_o_valid", o_valid, 0);
    chk("t6_rst_sat", o_sat_cnt, 0);
    i_valid = 1'b0;
    cyc();
    rst_n         = 1'b1;
    i_func        = 2'd0;
    i_partial_sum = {4{16'h0280}};
    i_valid       = 1'b1;
    cyc();
    i_valid = 1'b0;
    cyc();
    chk("t6_table_identity", o_act, {4{16'h0280}});
    cyc();

    // random stream with random stalls and table rewrites
    repeat (3000) begin
      int r;
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 7);
      r       = int'($urandom_range(0, 5));
      i_func  = (r > 3) ? 2'd0 : 2'(r);
      for (int k = 0; k < G; k++) i_partial_sum[k*BW +: BW] = 16'($urandom);
      i_coef_we   = ($urandom_range(0, 9) == 0);
      i_coef_addr = 4'($urandom_range(0, 15));
      i_coef_a    = 16'(int'($urandom_range(0, 1022)) - 511);
      i_coef_b    = 16'($urandom);
      cyc();
    end
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    i_coef_we = 1'b0;
    repeat (5) cyc();
    chk("drain_empty", o_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
